mole_round_scheduler: RTL
=========================

Name: mole_round_scheduler

Overview:
- Sequences one game of whack-a-mole rounds.
- Each round: waits a gap interval, samples the mapped LFSR box value (1..4), lights that box for a fixed reaction window, then scores a correct hit or counts a miss.
- Sits between the LFSR/box-mapping path and the display/score logic.
- Drives the active box index, score and miss counters, and game-over status.

Parameters:
- TICK_DIV, 50000, CLOCK_50 cycles per timing tick (1 ms at 50 MHz); 2..2^20
- GAP_TICKS, 500, ticks of dark gap before each box lights; 1..65535
- WINDOW_TICKS, 1000, ticks a box stays lit awaiting a hit; 1..65535
- NUM_ROUNDS, 10, rounds per game; 1..255
- AVOID_REPEAT, 1, 1 = re-pick when the sampled box equals the previous round's box

Ports:
- CLOCK_50  in  1  system clock
- reset_signal  in  1  asynchronous, active-high reset
- start  in  1  level; begins a game from IDLE or DONE
- lfsr_box  in  3  mapped LFSR box value, valid range 1..4
- hit_valid  in  1  single-cycle strobe: player struck a box
- hit_box  in  3  box struck (1..4), qualified by hit_valid
- active_box  out  3  box currently lit, 0 = none
- box_onehot  out  4  one-hot of active_box (bit0 = box 1), 0 when none
- score  out  8  correct hits this game, saturating at 255
- misses  out  8  wrong hits plus timeouts this game, saturating at 255
- rounds_left  out  8  rounds remaining
- round_done  out  1  one-cycle pulse at end of each round
- round_hit  out  1  valid with round_done: 1 = round scored
- game_over  out  1  high in DONE
- busy  out  1  high in GAP, PICK, SHOW, RESULT

Behaviour:
- Reset (async, any state):
  - state = IDLE
  - all outputs 0
  - prev_box = 0; tick divider and phase counters = 0
- States: IDLE, GAP, PICK, SHOW, RESULT, DONE. All transitions registered on posedge CLOCK_50.
- IDLE / DONE, start = 1:
  - next state GAP
  - score = 0, misses = 0, rounds_left = NUM_ROUNDS, prev_box = 0
  - game_over cleared on that edge
- Tick divider and phase counter restart at 0 on every entry to GAP or SHOW.
  - A tick occurs when the divider reaches TICK_DIV-1.
  - A phase ends on the tick that brings the phase count to its limit.
  - GAP therefore occupies exactly GAP_TICKS*TICK_DIV cycles; SHOW occupies at most WINDOW_TICKS*TICK_DIV cycles.
- GAP:
  - active_box = 0
  - on gap expiry -> PICK
  - hit_valid ignored; no score or miss change
- PICK (one or more cycles):
  - Sample lfsr_box each cycle.
  - Accept if 1..4 and (AVOID_REPEAT = 0, or value != prev_box, or 3 consecutive repeat rejections already occurred).
  - Out-of-range values always reject, with no retry limit.
  - On accept: active_box = value, prev_box = value -> SHOW.
- SHOW:
  - box_onehot = decode(active_box)
  - hit_valid with hit_box == active_box: score+1 (saturate), round_hit = 1 -> RESULT
  - hit_valid with hit_box != active_box: misses+1, round_hit = 0 -> RESULT
  - window expiry, no hit: misses+1, round_hit = 0 -> RESULT
  - Hit and expiry in the same cycle: the hit is evaluated and the timeout is ignored.
  - Counters update on the same edge that enters RESULT.
- RESULT (exactly one cycle):
  - round_done = 1; round_hit holds the outcome
  - active_box = 0, box_onehot = 0
  - rounds_left decrements on exit
  - next state DONE if rounds_left was 1, else GAP
- DONE: game_over = 1; score and misses held; busy = 0.
- start while busy: ignored.
- hit_valid outside SHOW: ignored.
- round_hit outside RESULT: 0.

Test Plan:
- Common overrides for all scenarios: TICK_DIV=4, GAP_TICKS=2, WINDOW_TICKS=3, NUM_ROUNDS=3, AVOID_REPEAT=1.
- Reset then start pulse, lfsr_box = 2 -> GAP lasts 8 cycles; active_box = 2 and box_onehot = 4'b0010 one cycle later; SHOW lasts 12 cycles; misses = 1, round_done pulses once, rounds_left = 2.
- In SHOW with active_box = 3, hit_valid with hit_box = 3 -> next cycle score = 1, round_done = 1, round_hit = 1, active_box = 0.
- In SHOW, hit_box = 1 while active_box = 4 -> misses increments, round_hit = 0; a second hit_valid during the following GAP changes nothing.
- lfsr_box held at 2 equal to prev_box -> PICK rejects 3 cycles and accepts on the 4th. lfsr_box = 0 or 7 -> PICK holds indefinitely with active_box = 0.
- Three rounds completed -> game_over = 1, busy = 0, rounds_left = 0, score + misses = 3. start then clears score, misses and game_over and reloads rounds_left = 3.
- Assert reset_signal mid-SHOW (asynchronously, between edges) -> all outputs 0 immediately; state IDLE; a later start begins a fresh game.

Source files
------------

// File: rtl/mole_round_scheduler_if.sv
// Handshake bundle between the mole round scheduler and the surrounding
// game logic (LFSR/box mapping in, display/score out).
interface mole_round_scheduler_if;
  logic       start;
  logic [2:0] lfsr_box;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic [2:0] active_box;
  logic [3:0] box_onehot;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] rounds_left;
  logic       round_done;
  logic       round_hit;
  logic       game_over;
  logic       busy;

  modport slave (
    input  start, lfsr_box, hit_valid, hit_box,
    output active_box, box_onehot, score, misses, rounds_left,
           round_done, round_hit, game_over, busy
  );

  modport master (
    output start, lfsr_box, hit_valid, hit_box,
    input  active_box, box_onehot, score, misses, rounds_left,
           round_done, round_hit, game_over, busy
  );
endinterface

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: dark gap, box pick, timed reaction window,
// then score or miss, for a fixed number of rounds per game.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// GAP    | dark interval before the next box lights
// PICK   | sampling lfsr_box until an acceptable box appears
// SHOW   | box lit, waiting for a hit or window expiry
// RESULT | one-cycle round outcome (round_done pulse)
// DONE   | game finished, results held until the next start
module mole_round_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int GAP_TICKS    = 500,
  parameter int WINDOW_TICKS = 1000,
  parameter int NUM_ROUNDS   = 10,
  parameter int AVOID_REPEAT = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_signal,
  mole_round_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PICK,
    S_SHOW,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [19:0] DIV_LAST    = 20'(TICK_DIV - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_TICKS - 1);
  localparam logic [15:0] WIN_LAST    = 16'(WINDOW_TICKS - 1);
  localparam logic [7:0]  ROUNDS_INIT = 8'(NUM_ROUNDS);

  state_t      state;
  logic [19:0] div_cnt;
  logic [15:0] phase_cnt;
  logic [2:0]  prev_box;
  logic [1:0]  rej_cnt;

  logic tick;
  logic gap_end;
  logic win_end;
  logic pick_in_range;
  logic pick_ok;
  logic hit_match;

  function automatic logic [3:0] onehot_of(input logic [2:0] b);
    logic [3:0] v;
    v = 4'b0000;
    case (b)
      3'd1:    v = 4'b0001;
      3'd2:    v = 4'b0010;
      3'd3:    v = 4'b0100;
      3'd4:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  always_comb begin
    tick          = (div_cnt == DIV_LAST);
    gap_end       = tick && (phase_cnt == GAP_LAST);
    win_end       = tick && (phase_cnt == WIN_LAST);
    pick_in_range = (bus.lfsr_box >= 3'd1) && (bus.lfsr_box <= 3'd4);
    // After three straight repeat rejections the repeat is let through so PICK cannot stall on a stuck LFSR.
    pick_ok       = pick_in_range &&
                    ((AVOID_REPEAT == 0) || (bus.lfsr_box != prev_box) || (rej_cnt == 2'd3));
    hit_match     = (bus.hit_box == bus.active_box);
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state           <= S_IDLE;
      div_cnt         <= '0;
      phase_cnt       <= '0;
      prev_box        <= '0;
      rej_cnt         <= '0;
      bus.active_box  <= '0;
      bus.box_onehot  <= '0;
      bus.score       <= '0;
      bus.misses      <= '0;
      bus.rounds_left <= '0;
      bus.round_done  <= 1'b0;
      bus.round_hit   <= 1'b0;
      bus.game_over   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      if (state == S_GAP || state == S_SHOW) begin
        if (tick) begin
          div_cnt   <= '0;
          phase_cnt <= phase_cnt + 16'd1;
        end else begin
          div_cnt   <= div_cnt + 20'd1;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state           <= S_GAP;
            div_cnt         <= '0;
            phase_cnt       <= '0;
            prev_box        <= '0;
            bus.score       <= '0;
            bus.misses      <= '0;
            bus.rounds_left <= ROUNDS_INIT;
            bus.game_over   <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end

        S_GAP: begin
          if (gap_end) begin
            state   <= S_PICK;
            rej_cnt <= '0;
          end
        end

        S_PICK: begin
          if (pick_ok) begin
            state          <= S_SHOW;
            div_cnt        <= '0;
            phase_cnt      <= '0;
            prev_box       <= bus.lfsr_box;
            bus.active_box <= bus.lfsr_box;
            bus.box_onehot <= onehot_of(bus.lfsr_box);
          end else if (pick_in_range) begin
            rej_cnt <= rej_cnt + 2'd1;
          end
        end

        S_SHOW: begin
          // A hit landing on the expiry tick still counts as a hit.
          if (bus.hit_valid || win_end) begin
            state          <= S_RESULT;
            bus.round_done <= 1'b1;
            bus.active_box <= '0;
            bus.box_onehot <= '0;
            if (bus.hit_valid && hit_match) begin
              bus.round_hit <= 1'b1;
              if (bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
            end else begin
              if (bus.misses != 8'hFF) bus.misses <= bus.misses + 8'd1;
            end
          end
        end

        S_RESULT: begin
          bus.round_done  <= 1'b0;
          bus.round_hit   <= 1'b0;
          bus.rounds_left <= bus.rounds_left - 8'd1;
          if (bus.rounds_left == 8'd1) begin
            state         <= S_DONE;
            bus.game_over <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            state     <= S_GAP;
            div_cnt   <= '0;
            phase_cnt <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
